ika9958_cpu_regwr: RTL and testbench

- CPU-port write sequencer sitting directly upstream of the VDP register file.
- Decodes CPU writes to ports #1 (control), #2 (palette) and #3 (indirect register), and tracks the two-byte phase flip-flops.
- Emits single-cycle register-write and palette-write strobes that the register file and palette RAM consume.
- Keeps private copies of the R#16 (palette pointer) and R#17 (indirect pointer) registers for auto-increment.

---
 rtl/ika9958_cpu_regwr.sv | 217 +++++++++++++++++++++
 tb/tb_ika9958_cpu_regwr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_cpu_regwr.sv
`default_nettype none
// ============================================================================
// Module   : ika9958_cpu_regwr
// Purpose  : CPU-port write sequencer in front of the VDP register file.
//            Decodes CPU writes to port 1 (control), port 2 (palette) and
//            port 3 (indirect register). Tracks the two-byte phase flops and
//            emits one-cycle register, VRAM-address and palette strobes.
//            Keeps private copies of R#16 (palette pointer) and R#17
//            (indirect pointer) so both can auto-increment locally.
// Ports    : i_EMUCLK        master clock, rising edge
//            i_RST           asynchronous active-high reset
//            i_wr / i_rd     one-cycle CPU write / read strobes (synchronised)
//            i_a[1:0]        port select 0..3
//            i_d[7:0]        CPU write data
//            o_reg_we        register write strobe
//            o_reg_addr[5:0] register index
//            o_reg_data[7:0] register data
//            o_vaddr_we      VRAM address-setup strobe
//            o_vaddr_data    {second[5:0], first[7:0]}
//            o_vaddr_rdmode  second[6]: 0 = read-ahead, 1 = write
//            o_pal_we        palette write strobe
//            o_pal_idx[3:0]  palette entry index
//            o_pal_rgb[8:0]  {R[2:0], B[2:0], G[2:0]}
// Revision : 1.0 - initial release
// ============================================================================
module ika9958_cpu_regwr #(
    parameter int REG_MAX = 46
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic [1:0]  i_a,
    input  logic [7:0]  i_d,
    output logic        o_reg_we,
    output logic [5:0]  o_reg_addr,
    output logic [7:0]  o_reg_data,
    output logic        o_vaddr_we,
    output logic [13:0] o_vaddr_data,
    output logic        o_vaddr_rdmode,
    output logic        o_pal_we,
    output logic [3:0]  o_pal_idx,
    output logic [8:0]  o_pal_rgb
);

    localparam logic [6:0] c_REG_MAX  = 7'(REG_MAX);
    localparam logic [5:0] c_IDX_R16  = 6'd16;
    localparam logic [5:0] c_IDX_R17  = 6'd17;

    // Sequencer state
    logic       r_ctl_phase;
    logic [7:0] r_ctl_latch;
    logic       r_pal_phase;
    logic [5:0] r_pal_latch;   // only {R[2:0], B[2:0]} of the first byte matter
    logic [7:0] r_r16;
    logic [7:0] r_r17;

    logic       w_ctl_phase_nxt;
    logic [7:0] w_ctl_latch_nxt;
    logic       w_pal_phase_nxt;
    logic [5:0] w_pal_latch_nxt;
    logic [7:0] w_r16_nxt;
    logic [7:0] w_r17_nxt;

    logic       w_wr1;
    logic       w_wr2;
    logic       w_wr3;
    logic       w_ctl_phase_eff;

    logic       w_reg_hit;
    logic [5:0] w_reg_addr;
    logic [7:0] w_reg_data;
    logic       w_reg_we;
    logic       w_vaddr_hit;
    logic [13:0] w_vaddr_data;
    logic       w_vaddr_rdmode;
    logic       w_pal_hit;
    logic [3:0] w_pal_idx;
    logic [8:0] w_pal_rgb;

    assign w_wr1 = i_wr && (i_a == 2'd1);
    assign w_wr2 = i_wr && (i_a == 2'd2);
    assign w_wr3 = i_wr && (i_a == 2'd3);

    // A same-cycle read on port 1 clears the phase before the write is seen,
    // so the write then counts as a first byte.
    assign w_ctl_phase_eff = r_ctl_phase && !(i_rd && (i_a == 2'd1));

    always_comb begin
        w_ctl_phase_nxt = r_ctl_phase;
        w_ctl_latch_nxt = r_ctl_latch;
        w_pal_phase_nxt = r_pal_phase;
        w_pal_latch_nxt = r_pal_latch;
        w_r16_nxt       = r_r16;
        w_r17_nxt       = r_r17;
        w_reg_hit       = 1'b0;
        w_reg_addr      = 6'd0;
        w_reg_data      = 8'd0;
        w_vaddr_hit     = 1'b0;
        w_vaddr_data    = {i_d[5:0], r_ctl_latch};
        w_vaddr_rdmode  = i_d[6];
        w_pal_hit       = 1'b0;
        w_pal_idx       = r_r16[3:0];
        w_pal_rgb       = {r_pal_latch, i_d[2:0]};

        // Any port 0 access, or a port 1 read, resynchronises the control pair
        if ((i_wr || i_rd) && (i_a == 2'd0)) begin
            w_ctl_phase_nxt = 1'b0;
        end
        if (i_rd && (i_a == 2'd1)) begin
            w_ctl_phase_nxt = 1'b0;
        end

        if (w_wr1) begin
            if (!w_ctl_phase_eff) begin
                w_ctl_latch_nxt = i_d;
                w_ctl_phase_nxt = 1'b1;
            end else begin
                w_ctl_phase_nxt = 1'b0;
                case (i_d[7:6])
                    2'b10: begin
                        w_reg_hit  = 1'b1;
                        w_reg_addr = i_d[5:0];
                        w_reg_data = r_ctl_latch;
                    end
                    2'b00, 2'b01: w_vaddr_hit = 1'b1;
                    default: ;
                endcase
            end
        end

        if (w_wr3) begin
            // R#17 cannot be rewritten through itself, yet the pointer still moves
            if (r_r17[5:0] != c_IDX_R17) begin
                w_reg_hit  = 1'b1;
                w_reg_addr = r_r17[5:0];
                w_reg_data = i_d;
            end
            if (!r_r17[7]) begin
                w_r17_nxt = {r_r17[7:6], r_r17[5:0] + 6'd1};
            end
        end

        if (w_wr2) begin
            if (!r_pal_phase) begin
                w_pal_latch_nxt = {i_d[6:4], i_d[2:0]};
                w_pal_phase_nxt = 1'b1;
            end else begin
                w_pal_hit       = 1'b1;
                w_r16_nxt       = {r_r16[7:4], r_r16[3:0] + 4'd1};
                w_pal_phase_nxt = 1'b0;
            end
        end

        // Shadow loads are applied last so they win over any increment
        if (w_reg_hit) begin
            if (w_reg_addr == c_IDX_R16) begin
                w_r16_nxt       = w_reg_data;
                w_pal_phase_nxt = 1'b0;
            end
            if (w_reg_addr == c_IDX_R17) begin
                w_r17_nxt = w_reg_data;
            end
        end
    end

    // Shadowing above is independent of the implemented range; only the
    // outgoing strobe is gated.
    assign w_reg_we = w_reg_hit && ({1'b0, w_reg_addr} < c_REG_MAX);

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            r_ctl_phase    <= 1'b0;
            r_ctl_latch    <= 8'd0;
            r_pal_phase    <= 1'b0;
            r_pal_latch    <= 6'd0;
            r_r16          <= 8'd0;
            r_r17          <= 8'd0;
            o_reg_we       <= 1'b0;
            o_reg_addr     <= 6'd0;
            o_reg_data     <= 8'd0;
            o_vaddr_we     <= 1'b0;
            o_vaddr_data   <= 14'd0;
            o_vaddr_rdmode <= 1'b0;
            o_pal_we       <= 1'b0;
            o_pal_idx      <= 4'd0;
            o_pal_rgb      <= 9'd0;
        end else begin
            r_ctl_phase <= w_ctl_phase_nxt;
            r_ctl_latch <= w_ctl_latch_nxt;
            r_pal_phase <= w_pal_phase_nxt;
            r_pal_latch <= w_pal_latch_nxt;
            r_r16       <= w_r16_nxt;
            r_r17       <= w_r17_nxt;

            o_reg_we   <= w_reg_we;
            o_vaddr_we <= w_vaddr_hit;
            o_pal_we   <= w_pal_hit;

            // Data outputs hold between strobes
            if (w_reg_we) begin
                o_reg_addr <= w_reg_addr;
                o_reg_data <= w_reg_data;
            end
            if (w_vaddr_hit) begin
                o_vaddr_data   <= w_vaddr_data;
                o_vaddr_rdmode <= w_vaddr_rdmode;
            end
            if (w_pal_hit) begin
                o_pal_idx <= w_pal_idx;
                o_pal_rgb <= w_pal_rgb;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ika9958_cpu_regwr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ika9958_cpu_regwr
// Purpose  : Self-checking bench for ika9958_cpu_regwr. Two instances share
//            the stimulus: one with REG_MAX = 46, one with REG_MAX = 64.
//            Directed vector table, reset-in-flight sequence and random
//            traffic, all compared against a behavioural port model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ika9958_cpu_regwr;

    logic        clk;
    logic        rst;
    logic        tb_wr;
    logic        tb_rd;
    logic [1:0]  tb_a;
    logic [7:0]  tb_d;

    logic        reg_we_a, reg_we_b;
    logic [5:0]  reg_addr_a, reg_addr_b;
    logic [7:0]  reg_data_a, reg_data_b;
    logic        vaddr_we_a, vaddr_we_b;
    logic [13:0] vaddr_data_a, vaddr_data_b;
    logic        vaddr_rdmode_a, vaddr_rdmode_b;
    logic        pal_we_a, pal_we_b;
    logic [3:0]  pal_idx_a, pal_idx_b;
    logic [8:0]  pal_rgb_a, pal_rgb_b;

    ika9958_cpu_regwr #(.REG_MAX(46)) u_dut46 (
        .i_EMUCLK(clk), .i_RST(rst), .i_wr(tb_wr), .i_rd(tb_rd), .i_a(tb_a), .i_d(tb_d),
        .o_reg_we(reg_we_a), .o_reg_addr(reg_addr_a), .o_reg_data(reg_data_a),
        .o_vaddr_we(vaddr_we_a), .o_vaddr_data(vaddr_data_a), .o_vaddr_rdmode(vaddr_rdmode_a),
        .o_pal_we(pal_we_a), .o_pal_idx(pal_idx_a), .o_pal_rgb(pal_rgb_a)
    );

    ika9958_cpu_regwr #(.REG_MAX(64)) u_dut64 (
        .i_EMUCLK(clk), .i_RST(rst), .i_wr(tb_wr), .i_rd(tb_rd), .i_a(tb_a), .i_d(tb_d),
        .o_reg_we(reg_we_b), .o_reg_addr(reg_addr_b), .o_reg_data(reg_data_b),
        .o_vaddr_we(vaddr_we_b), .o_vaddr_data(vaddr_data_b), .o_vaddr_rdmode(vaddr_rdmode_b),
        .o_pal_we(pal_we_b), .o_pal_idx(pal_idx_b), .o_pal_rgb(pal_rgb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [44:0] act_a, act_b;
    assign act_a = {reg_we_a, reg_addr_a, reg_data_a, vaddr_we_a, vaddr_data_a,
                    vaddr_rdmode_a, pal_we_a, pal_idx_a, pal_rgb_a};
    assign act_b = {reg_we_b, reg_addr_b, reg_data_b, vaddr_we_b, vaddr_data_b,
                    vaddr_rdmode_b, pal_we_b, pal_idx_b, pal_rgb_b};

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model of the CPU ports ----------------
    int m_cphase, m_clatch, m_pphase, m_platch, m_r16, m_r17;
    logic        e_reg_we[2];
    logic [5:0]  e_reg_addr[2];
    logic [7:0]  e_reg_data[2];
    logic        e_vaddr_we;
    logic [13:0] e_vaddr_data;
    logic        e_vaddr_rdmode;
    logic        e_pal_we;
    logic [3:0]  e_pal_idx;
    logic [8:0]  e_pal_rgb;

    function automatic int regmax(input int k);
        return (k == 0) ? 46 : 64;
    endfunction

    task automatic model_reset();
        m_cphase = 0; m_clatch = 0; m_pphase = 0; m_platch = 0; m_r16 = 0; m_r17 = 0;
        for (int k = 0; k < 2; k++) begin
            e_reg_we[k] = 1'b0; e_reg_addr[k] = 6'd0; e_reg_data[k] = 8'd0;
        end
        e_vaddr_we = 1'b0; e_vaddr_data = 14'd0; e_vaddr_rdmode = 1'b0;
        e_pal_we = 1'b0; e_pal_idx = 4'd0; e_pal_rgb = 9'd0;
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] d);
        int dv, tgt, val;
        bit do_reg;
        dv = int'(d); tgt = 0; val = 0; do_reg = 0;
        e_reg_we[0] = 1'b0; e_reg_we[1] = 1'b0; e_vaddr_we = 1'b0; e_pal_we = 1'b0;
        if ((a == 2'd0 && (wr || rd)) || (a == 2'd1 && rd)) m_cphase = 0;
        if (wr) begin
            case (a)
                2'd1: begin
                    if (m_cphase == 0) begin
                        m_clatch = dv; m_cphase = 1;
                    end else begin
                        m_cphase = 0;
                        if (dv >= 128 && dv < 192) begin
                            do_reg = 1; tgt = dv % 64; val = m_clatch;
                        end else if (dv < 128) begin
                            e_vaddr_we     = 1'b1;
                            e_vaddr_data   = 14'((dv % 64) * 256 + m_clatch);
                            e_vaddr_rdmode = (dv >= 64);
                        end
                    end
                end
                2'd2: begin
                    if (m_pphase == 0) begin
                        m_platch = dv; m_pphase = 1;
                    end else begin
                        e_pal_we  = 1'b1;
                        e_pal_idx = 4'(m_r16 % 16);
                        e_pal_rgb = 9'(((m_platch / 16) % 8) * 64 + (m_platch % 8) * 8 + (dv % 8));
                        m_r16     = (m_r16 / 16) * 16 + (m_r16 + 1) % 16;
                        m_pphase  = 0;
                    end
                end
                2'd3: begin
                    tgt = m_r17 % 64;
                    if (tgt != 17) begin do_reg = 1; val = dv; end
                    if (m_r17 < 128) m_r17 = (m_r17 / 64) * 64 + (m_r17 + 1) % 64;
                end
                default: ;
            endcase
        end
        if (do_reg) begin
            for (int k = 0; k < 2; k++) begin
                if (tgt < regmax(k)) begin
                    e_reg_we[k] = 1'b1; e_reg_addr[k] = 6'(tgt); e_reg_data[k] = 8'(val);
                end
            end
            if (tgt == 16) begin m_r16 = val; m_pphase = 0; end
            if (tgt == 17) m_r17 = val;
        end
    endtask

    function automatic logic [44:0] exp_bundle(input int k);
        return {e_reg_we[k], e_reg_addr[k], e_reg_data[k], e_vaddr_we, e_vaddr_data,
                e_vaddr_rdmode, e_pal_we, e_pal_idx, e_pal_rgb};
    endfunction

    task automatic check_bundles(input string name);
        checks++;
        if (act_a !== exp_bundle(0)) begin
            errors++;
            $display("FAIL %s dut46: got %h expected %h at %0t", name, act_a, exp_bundle(0), $time);
        end
        checks++;
        if (act_b !== exp_bundle(1)) begin
            errors++;
            $display("FAIL %s dut64: got %h expected %h at %0t", name, act_b, exp_bundle(1), $time);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, compare
    task automatic cycle(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] d,
                         input string name);
        tb_wr = wr; tb_rd = rd; tb_a = a; tb_d = d;
        model_step(wr, rd, a, d);
        @(posedge clk);
        #1;
        check_bundles(name);
        tb_wr = 1'b0; tb_rd = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    // strb = {pal_we, vaddr_we, reg_we(64), reg_we(46)}
    // val  = reg: {2'b0,addr,data}  vaddr: {1'b0,rdmode,data}  pal: {3'b0,idx,rgb}
    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  a;
        logic [7:0]  d;
        logic [3:0]  strb;
        logic [15:0] val;
    } vec_t;

    vec_t vecs[$];

    task automatic addw(input logic [1:0] a, input logic [7:0] d, input logic [3:0] strb, input logic [15:0] val);
        vec_t v;
        v.wr = 1'b1; v.rd = 1'b0; v.a = a; v.d = d; v.strb = strb; v.val = val;
        vecs.push_back(v);
    endtask

    task automatic addv(input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] d);
        vec_t v;
        v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.strb = 4'b0000; v.val = 16'h0000;
        vecs.push_back(v);
    endtask

    logic [3:0]  got_strb;
    logic [15:0] got_val;

    initial begin
        rst = 1'b1; tb_wr = 1'b0; tb_rd = 1'b0; tb_a = 2'd0; tb_d = 8'd0;
        model_reset();

        // port 1 register write, then idle to confirm the strobe is one cycle
        addw(2'd1, 8'h06, 4'b0000, 16'h0000);
        addw(2'd1, 8'h80, 4'b0011, 16'h0006);
        addv(1'b0, 1'b0, 2'd1, 8'h00);
        // VRAM address setup
        addw(2'd1, 8'h34, 4'b0000, 16'h0000);
        addw(2'd1, 8'h52, 4'b0100, 16'h5234);
        // phase cleared by a port 1 read
        addw(2'd1, 8'hAA, 4'b0000, 16'h0000);
        addv(1'b0, 1'b1, 2'd1, 8'h00);
        addw(2'd1, 8'h55, 4'b0000, 16'h0000);
        addw(2'd1, 8'h89, 4'b0011, 16'h0955);
        // read and write together: the write is a first byte
        addw(2'd1, 8'hAA, 4'b0000, 16'h0000);
        addv(1'b1, 1'b1, 2'd1, 8'h55);
        addw(2'd1, 8'h89, 4'b0011, 16'h0955);
        // port 0 access clears the phase; 11 decode is dropped
        addw(2'd1, 8'h12, 4'b0000, 16'h0000);
        addv(1'b0, 1'b1, 2'd0, 8'h00);
        addw(2'd1, 8'h88, 4'b0000, 16'h0000);
        addw(2'd1, 8'h80, 4'b0011, 16'h0088);
        addw(2'd1, 8'h12, 4'b0000, 16'h0000);
        addw(2'd1, 8'hC5, 4'b0000, 16'h0000);
        // R#17 = 0x3E then indirect writes across the pointer wrap
        addw(2'd1, 8'h3E, 4'b0000, 16'h0000);
        addw(2'd1, 8'h91, 4'b0011, 16'h113E);
        addw(2'd3, 8'h11, 4'b0010, 16'h3E11);
        addw(2'd3, 8'h22, 4'b0010, 16'h3F22);
        addw(2'd3, 8'h33, 4'b0011, 16'h0033);
        // R#17 = 0x91: targets R#17, no increment
        addw(2'd1, 8'h91, 4'b0000, 16'h0000);
        addw(2'd1, 8'h91, 4'b0011, 16'h1191);
        addw(2'd3, 8'h44, 4'b0000, 16'h0000);
        addw(2'd3, 8'h55, 4'b0000, 16'h0000);
        addw(2'd3, 8'h66, 4'b0000, 16'h0000);
        // R#16 = 15, palette pair, then the pointer wraps to 0
        addw(2'd1, 8'h0F, 4'b0000, 16'h0000);
        addw(2'd1, 8'h90, 4'b0011, 16'h100F);
        addw(2'd2, 8'h75, 4'b0000, 16'h0000);
        addw(2'd2, 8'h03, 4'b1000, 16'h1FEB);
        addw(2'd2, 8'h77, 4'b0000, 16'h0000);
        addw(2'd2, 8'h05, 4'b1000, 16'h01FD);
        // R#16 written between palette bytes resets the palette phase
        addw(2'd2, 8'h12, 4'b0000, 16'h0000);
        addw(2'd1, 8'h02, 4'b0000, 16'h0000);
        addw(2'd1, 8'h90, 4'b0011, 16'h1002);
        addw(2'd2, 8'h70, 4'b0000, 16'h0000);
        addw(2'd2, 8'h01, 4'b1000, 16'h05C1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_bundles("reset_state");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, "vec_model");
            got_strb = {pal_we_b, vaddr_we_b, reg_we_b, reg_we_a};
            if (reg_we_b)        got_val = {2'b00, reg_addr_b, reg_data_b};
            else if (vaddr_we_b) got_val = {1'b0, vaddr_rdmode_b, vaddr_data_b};
            else if (pal_we_b)   got_val = {3'b000, pal_idx_b, pal_rgb_b};
            else                 got_val = 16'h0000;
            checks++;
            if (got_strb !== vecs[i].strb || got_val !== vecs[i].val) begin
                errors++;
                $display("FAIL vec[%0d]: got strb=%b val=%h expected strb=%b val=%h",
                         i, got_strb, got_val, vecs[i].strb, vecs[i].val);
            end
        end

        // Reset in the middle of two-byte sequences with held data outputs
        cycle(1'b1, 1'b0, 2'd2, 8'h75, "pre_reset");
        cycle(1'b1, 1'b0, 2'd1, 8'h06, "pre_reset");
        cycle(1'b1, 1'b0, 2'd1, 8'h85, "pre_reset");
        cycle(1'b1, 1'b0, 2'd1, 8'h12, "pre_reset");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_bundles("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 2'd1, 8'h80, "post_reset_p1");
        cycle(1'b1, 1'b0, 2'd2, 8'h07, "post_reset_p2");
        cycle(1'b0, 1'b0, 2'd0, 8'h00, "post_reset_idle");

        // Random traffic, biased toward register writes and the pointer registers
        for (int n = 0; n < 4000; n++) begin
            logic       rw, rr;
            logic [1:0] ra;
            logic [7:0] rdat;
            ra   = 2'($urandom_range(0, 3));
            rw   = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 9) == 0);
            rdat = 8'($urandom);
            if (ra == 2'd1 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0:       rdat = 8'h90;
                    1:       rdat = 8'h91;
                    default: rdat = {2'b10, 6'($urandom)};
                endcase
            end
            cycle(rw, rr, ra, rdat, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
